// File: rtl/y86_writeback.sv
// rtl/y86_writeback.sv - SEQ Y86-64 write-back stage and register file owner
//
// Derives dstE/dstM from icode, rA, rB and cnd, then commits valE/valM into
// a 15-entry register file (%rax..%r14) on the rising edge of clk.
// Tracks processor status with a RUN/HALT/FAULT state machine.
// Counts retired instructions.
//
// Optional feature macro: Y86_WB_BYPASS_EN
//   defined   - rdA/rdB forward the value being committed in the same cycle
//   undefined - rdA/rdB return the array contents only
//
// Parameters:
//   DATA_W     register and data width
//   RSP_RESET  reset value of %rsp (register 4)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wb_valid            an instruction is retiring this cycle
//   icode, rA, rB, cnd  instruction fields and execute condition
//   mem_error           data-memory address error for this instruction
//   valE, valM          ALU result and memory read data
//   srcA, srcB          decode read addresses (4'hF = none)
//   rdA, rdB            read data, 0 for source 4'hF
//   stat                1=AOK 2=HLT 3=ADR 4=INS
//   halted              high in any state other than RUN
//   retired             count of committed instructions (wraps)

module y86_writeback #(
   parameter int unsigned          DATA_W    = 64,
   parameter logic [DATA_W-1:0]    RSP_RESET = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_valid,
   input  logic [3:0]        icode,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic              cnd,
   input  logic              mem_error,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valM,
   input  logic [3:0]        srcA,
   input  logic [3:0]        srcB,
   output logic [DATA_W-1:0] rdA,
   output logic [DATA_W-1:0] rdB,
   output logic [2:0]        stat,
   output logic              halted,
   output logic [31:0]       retired
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'd4;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_CMOV   = 4'h2;
   localparam logic [3:0] I_IRMOV  = 4'h3;
   localparam logic [3:0] I_MRMOV  = 4'h5;
   localparam logic [3:0] I_OP     = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSH   = 4'hA;
   localparam logic [3:0] I_POP    = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_HALT      = 2'd1,
      ST_FAULT_ADR = 2'd2,
      ST_FAULT_INS = 2'd3
   } state_t;

   state_t state;

   logic [DATA_W-1:0] regs [0:14];

   logic [3:0] dst_e;
   logic [3:0] dst_m;
   logic       icode_ok;
   logic       commit;
   logic       retire;

   // Destination selection
   always_comb begin
      dst_e = RNONE;
      unique case (icode)
         I_CMOV:                       dst_e = cnd ? rB : RNONE;
         I_IRMOV, I_OP:                dst_e = rB;
         I_CALL, I_RET, I_PUSH, I_POP: dst_e = RSP;
         default:                      dst_e = RNONE;
      endcase
   end

   always_comb begin
      dst_m = RNONE;
      if (icode == I_MRMOV || icode == I_POP)
         dst_m = rA;
   end

   assign icode_ok = (icode <= I_POP);

   // Register writes only happen for a clean instruction while running.
   // Halt also qualifies here but its destinations are both RNONE.
   assign commit = wb_valid && (state == ST_RUN) && icode_ok && !mem_error;

   // A halt retires even if the memory stage flagged an error: halt makes
   // no data access, so the flag cannot belong to it.
   assign retire = wb_valid && (state == ST_RUN) &&
                   ((icode == I_HALT) || (icode_ok && !mem_error));

   // Register file
   always_ff @(posedge clk) begin
      for (int i = 0; i < 15; i++) begin
         if (reset) begin
            regs[i] <= (i == 4) ? RSP_RESET : '0;
         end else if (commit) begin
            // valM wins when both ports target the same register (popq %rsp)
            if (dst_m == 4'(i))
               regs[i] <= valM;
            else if (dst_e == 4'(i))
               regs[i] <= valE;
         end
      end
   end

   // Status state machine and retired counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_RUN;
         stat    <= STAT_AOK;
         halted  <= 1'b0;
         retired <= '0;
      end else begin
         if (wb_valid && state == ST_RUN) begin
            if (icode == I_HALT) begin
               state  <= ST_HALT;
               stat   <= STAT_HLT;
               halted <= 1'b1;
            end else if (!icode_ok) begin
               state  <= ST_FAULT_INS;
               stat   <= STAT_INS;
               halted <= 1'b1;
            end else if (mem_error) begin
               state  <= ST_FAULT_ADR;
               stat   <= STAT_ADR;
               halted <= 1'b1;
            end
         end
         if (retire)
            retired <= retired + 32'd1;
      end
   end

   // Read ports
   function automatic logic [DATA_W-1:0] read_port(input logic [3:0] src);
      logic [DATA_W-1:0] v;
      v = '0;
      if (src != RNONE) begin
         v = regs[src];
`ifdef Y86_WB_BYPASS_EN
         if (commit) begin
            if (dst_m == src)
               v = valM;
            else if (dst_e == src)
               v = valE;
         end
`endif
      end
      return v;
   endfunction

   assign rdA = read_port(srcA);
   assign rdB = read_port(srcB);

endmodule

// File: tb/tb_y86_writeback.sv
// tb/tb_y86_writeback.sv - directed self-checking bench for y86_writeback

module tb_y86_writeback;

   localparam int unsigned       DATA_W    = 64;
   localparam logic [63:0]       RSP_RST   = 64'h100;

   logic              clk;
   logic              reset;
   logic              wb_valid;
   logic [3:0]        icode;
   logic [3:0]        rA;
   logic [3:0]        rB;
   logic              cnd;
   logic              mem_error;
   logic [DATA_W-1:0] valE;
   logic [DATA_W-1:0] valM;
   logic [3:0]        srcA;
   logic [3:0]        srcB;
   logic [DATA_W-1:0] rdA;
   logic [DATA_W-1:0] rdB;
   logic [2:0]        stat;
   logic              halted;
   logic [31:0]       retired;

   int vectors;
   int miscompares;

   y86_writeback #(
      .DATA_W    (DATA_W),
      .RSP_RESET (RSP_RST)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wb_valid  (wb_valid),
      .icode     (icode),
      .rA        (rA),
      .rB        (rB),
      .cnd       (cnd),
      .mem_error (mem_error),
      .valE      (valE),
      .valM      (valM),
      .srcA      (srcA),
      .srcB      (srcB),
      .rdA       (rdA),
      .rdB       (rdB),
      .stat      (stat),
      .halted    (halted),
      .retired   (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_valid  = 1'b0;
      icode     = 4'h1;
      rA        = 4'hF;
      rB        = 4'hF;
      cnd       = 1'b0;
      mem_error = 1'b0;
      valE      = '0;
      valM      = '0;
   endtask

   task automatic retire_one(input logic [3:0] ic, input logic [3:0] ra,
                             input logic [3:0] rb, input logic c,
                             input logic me, input logic [63:0] ve,
                             input logic [63:0] vm);
      wb_valid  = 1'b1;
      icode     = ic;
      rA        = ra;
      rB        = rb;
      cnd       = c;
      mem_error = me;
      valE      = ve;
      valM      = vm;
      step();
      idle();
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      srcA = 4'd4;
      srcB = 4'd0;
      #1;
      vectors++;
      if (rdA !== 64'h100) begin
         miscompares++;
         $display("FAIL reset_rsp: got %h expected %h", rdA, 64'h100);
      end
      vectors++;
      if (rdB !== 64'h0) begin
         miscompares++;
         $display("FAIL reset_rax: got %h expected %h", rdB, 64'h0);
      end
      vectors++;
      if (stat !== 3'd1 || halted !== 1'b0 || retired !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_status: got stat=%0d halted=%0b retired=%0d expected 1 0 0",
                  stat, halted, retired);
      end
      srcA = 4'hF;
      #1;
      vectors++;
      if (rdA !== 64'h0) begin
         miscompares++;
         $display("FAIL read_rnone: got %h expected 0", rdA);
      end
   endtask

   task automatic test_irmov_cmov();
      retire_one(4'h3, 4'hF, 4'd2, 1'b0, 1'b0, 64'hDEAD, 64'h0);
      srcA = 4'd2;
      #1;
      vectors++;
      if (rdA !== 64'hDEAD || retired !== 32'd1) begin
         miscompares++;
         $display("FAIL irmovq: got rdx=%h retired=%0d expected dead 1", rdA, retired);
      end
      // cmov not taken
      retire_one(4'h2, 4'd2, 4'd3, 1'b0, 1'b0, 64'h1234, 64'h0);
      srcB = 4'd3;
      #1;
      vectors++;
      if (rdB !== 64'h0 || retired !== 32'd2) begin
         miscompares++;
         $display("FAIL cmov_not_taken: got rbx=%h retired=%0d expected 0 2", rdB, retired);
      end
      // cmov taken
      retire_one(4'h2, 4'd2, 4'd3, 1'b1, 1'b0, 64'h77, 64'h0);
      #1;
      vectors++;
      if (rdB !== 64'h77 || retired !== 32'd3) begin
         miscompares++;
         $display("FAIL cmov_taken: got rbx=%h retired=%0d expected 77 3", rdB, retired);
      end
      // wb_valid low: halt icode on the bus must be ignored
      wb_valid = 1'b0;
      icode    = 4'h0;
      step();
      idle();
      vectors++;
      if (stat !== 3'd1 || retired !== 32'd3) begin
         miscompares++;
         $display("FAIL idle_no_change: got stat=%0d retired=%0d expected 1 3", stat, retired);
      end
   endtask

   task automatic test_popq_rsp();
      retire_one(4'hB, 4'd4, 4'hF, 1'b0, 1'b0, 64'h108, 64'h500);
      srcA = 4'd4;
      #1;
      vectors++;
      if (rdA !== 64'h500 || retired !== 32'd4) begin
         miscompares++;
         $display("FAIL popq_rsp: got rsp=%h retired=%0d expected 500 4", rdA, retired);
      end
   endtask

   task automatic test_mem_error();
      retire_one(4'h5, 4'd1, 4'd6, 1'b0, 1'b1, 64'h40, 64'h7);
      srcA = 4'd1;
      #1;
      vectors++;
      if (rdA !== 64'h0) begin
         miscompares++;
         $display("FAIL adr_no_write: got rcx=%h expected 0", rdA);
      end
      vectors++;
      if (stat !== 3'd3 || halted !== 1'b1 || retired !== 32'd4) begin
         miscompares++;
         $display("FAIL adr_status: got stat=%0d halted=%0b retired=%0d expected 3 1 4",
                  stat, halted, retired);
      end
      retire_one(4'h3, 4'hF, 4'd2, 1'b0, 1'b0, 64'h99, 64'h0);
      srcA = 4'd2;
      #1;
      vectors++;
      if (rdA !== 64'hDEAD || retired !== 32'd4 || stat !== 3'd3) begin
         miscompares++;
         $display("FAIL adr_terminal: got rdx=%h retired=%0d stat=%0d expected dead 4 3",
                  rdA, retired, stat);
      end
   endtask

   task automatic test_bad_icode();
      do_reset();
      // invalid icode together with mem_error: instruction fault wins
      retire_one(4'hC, 4'd0, 4'd0, 1'b0, 1'b1, 64'h11, 64'h22);
      srcA = 4'd0;
      #1;
      vectors++;
      if (stat !== 3'd4 || halted !== 1'b1 || retired !== 32'd0 || rdA !== 64'h0) begin
         miscompares++;
         $display("FAIL ins_fault: got stat=%0d halted=%0b retired=%0d rax=%h expected 4 1 0 0",
                  stat, halted, retired, rdA);
      end
   endtask

   task automatic test_halt();
      do_reset();
      retire_one(4'h0, 4'hF, 4'hF, 1'b0, 1'b0, 64'h0, 64'h0);
      vectors++;
      if (stat !== 3'd2 || halted !== 1'b1 || retired !== 32'd1) begin
         miscompares++;
         $display("FAIL halt: got stat=%0d halted=%0b retired=%0d expected 2 1 1",
                  stat, halted, retired);
      end
      retire_one(4'h3, 4'hF, 4'd5, 1'b0, 1'b0, 64'h5, 64'h0);
      srcB = 4'd5;
      #1;
      vectors++;
      if (rdB !== 64'h0 || retired !== 32'd1) begin
         miscompares++;
         $display("FAIL halt_terminal: got rbp=%h retired=%0d expected 0 1", rdB, retired);
      end
      do_reset();
      vectors++;
      if (stat !== 3'd1 || halted !== 1'b0 || retired !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_from_halt: got stat=%0d halted=%0b retired=%0d expected 1 0 0",
                  stat, halted, retired);
      end
   endtask

   task automatic test_reset_override();
      reset     = 1'b1;
      wb_valid  = 1'b1;
      icode     = 4'h3;
      rB        = 4'd5;
      valE      = 64'hABC;
      step();
      reset = 1'b0;
      idle();
      srcA = 4'd5;
      #1;
      vectors++;
      if (rdA !== 64'h0 || retired !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_override: got rbp=%h retired=%0d expected 0 0", rdA, retired);
      end
   endtask

   task automatic test_same_cycle_read();
      do_reset();
      srcA      = 4'd0;
      wb_valid  = 1'b1;
      icode     = 4'h3;
      rB        = 4'd0;
      valE      = 64'h55;
      #2;
      vectors++;
`ifdef Y86_WB_BYPASS_EN
      if (rdA !== 64'h55) begin
         miscompares++;
         $display("FAIL bypass_same_cycle: got %h expected 55", rdA);
      end
`else
      if (rdA !== 64'h0) begin
         miscompares++;
         $display("FAIL nobypass_same_cycle: got %h expected 0", rdA);
      end
`endif
      step();
      idle();
      #1;
      vectors++;
      if (rdA !== 64'h55) begin
         miscompares++;
         $display("FAIL read_after_write: got %h expected 55", rdA);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      srcA        = 4'hF;
      srcB        = 4'hF;
      idle();
      test_reset();
      test_irmov_cmov();
      test_popq_rsp();
      test_mem_error();
      test_bad_icode();
      test_halt();
      test_reset_override();
      test_same_cycle_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
